// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master FSM state encoding.
package axi_lite_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA,
        RESP
    } state_t;

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: one command in, one single-beat read or write on M_AXI, one response out.
// Every AXI-facing output is a flop, so no VALID/READY path runs combinationally through this block.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int LAT_WIDTH          = 16
) (
    input  logic                            axi_aclk,
    input  logic                            axi_areset,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [31:0]                     cmd_wdata,
    input  logic [3:0]                      cmd_wstrb,

    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_write,
    output logic [31:0]                     rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic [LAT_WIDTH-1:0]            rsp_latency,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,

    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    if (C_M_AXI_DATA_WIDTH != 32) begin : g_widthCheck
        $error("axi_lite_master: only C_M_AXI_DATA_WIDTH=32 is supported");
    end

    state_t                        r_state;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
    logic [31:0]                   r_wdata;
    logic [3:0]                    r_wstrb;
    logic                          r_write;
    logic                          r_awvalid;
    logic                          r_wvalid;
    logic                          r_arvalid;
    logic                          r_bready;
    logic                          r_rready;
    logic                          r_cmdReady;
    logic                          r_rspValid;
    logic [31:0]                   r_rspRdata;
    resp_t                         r_rspResp;
    logic [LAT_WIDTH-1:0]          r_latency;

    state_t                        w_stateNext;
    logic                          w_awvalidNext;
    logic                          w_wvalidNext;
    logic                          w_arvalidNext;
    logic                          w_breadyNext;
    logic                          w_rreadyNext;
    logic                          w_rspValidNext;
    logic                          w_cmdReadyNext;
    logic                          w_accept;
    logic                          w_capture;
    logic [31:0]                   w_captureData;
    resp_t                         w_captureResp;
    logic                          w_counting;

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            r_state    <= IDLE;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_arvalid  <= 1'b0;
            r_bready   <= 1'b0;
            r_rready   <= 1'b0;
            r_rspValid <= 1'b0;
            r_cmdReady <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_awvalid  <= w_awvalidNext;
            r_wvalid   <= w_wvalidNext;
            r_arvalid  <= w_arvalidNext;
            r_bready   <= w_breadyNext;
            r_rready   <= w_rreadyNext;
            r_rspValid <= w_rspValidNext;
            r_cmdReady <= w_cmdReadyNext;
        end
    end

    // AW and W retire independently; a channel whose VALID is already low counts as done.
    always_comb begin
        w_stateNext    = r_state;
        w_awvalidNext  = r_awvalid;
        w_wvalidNext   = r_wvalid;
        w_arvalidNext  = r_arvalid;
        w_breadyNext   = r_bready;
        w_rreadyNext   = r_rready;
        w_rspValidNext = r_rspValid;
        w_accept       = 1'b0;
        w_capture      = 1'b0;
        w_captureData  = '0;
        w_captureResp  = RESP_OKAY;
        case (r_state)
            IDLE: begin
                if (cmd_valid && r_cmdReady) begin
                    w_accept = 1'b1;
                    if (cmd_write) begin
                        w_stateNext   = WADDR;
                        w_awvalidNext = 1'b1;
                        w_wvalidNext  = 1'b1;
                    end else begin
                        w_stateNext   = RADDR;
                        w_arvalidNext = 1'b1;
                    end
                end
            end
            WADDR: begin
                if (r_awvalid && M_AXI_AWREADY) begin
                    w_awvalidNext = 1'b0;
                end
                if (r_wvalid && M_AXI_WREADY) begin
                    w_wvalidNext = 1'b0;
                end
                if ((!r_awvalid || M_AXI_AWREADY) && (!r_wvalid || M_AXI_WREADY)) begin
                    w_stateNext  = WRESP;
                    w_breadyNext = 1'b1;
                end
            end
            WRESP: begin
                if (M_AXI_BVALID && r_bready) begin
                    w_stateNext    = RESP;
                    w_breadyNext   = 1'b0;
                    w_rspValidNext = 1'b1;
                    w_capture      = 1'b1;
                    w_captureResp  = M_AXI_BRESP;
                end
            end
            RADDR: begin
                if (r_arvalid && M_AXI_ARREADY) begin
                    w_stateNext   = RDATA;
                    w_arvalidNext = 1'b0;
                    w_rreadyNext  = 1'b1;
                end
            end
            RDATA: begin
                if (M_AXI_RVALID && r_rready) begin
                    w_stateNext    = RESP;
                    w_rreadyNext   = 1'b0;
                    w_rspValidNext = 1'b1;
                    w_capture      = 1'b1;
                    w_captureData  = M_AXI_RDATA;
                    w_captureResp  = M_AXI_RRESP;
                end
            end
            RESP: begin
                if (rsp_ready && r_rspValid) begin
                    w_stateNext    = IDLE;
                    w_rspValidNext = 1'b0;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
        w_cmdReadyNext = (w_stateNext == IDLE);
    end

    assign w_counting = (r_state == WADDR) || (r_state == WRESP) ||
                        (r_state == RADDR) || (r_state == RDATA);

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_write    <= 1'b0;
            r_rspRdata <= '0;
            r_rspResp  <= RESP_OKAY;
            r_latency  <= '0;
        end else begin
            if (w_accept) begin
                r_addr    <= cmd_addr;
                r_wdata   <= cmd_wdata;
                r_wstrb   <= cmd_wstrb;
                r_write   <= cmd_write;
                r_latency <= '0;
            end else if (w_counting && (r_latency != '1)) begin
                r_latency <= r_latency + 1'b1;
            end
            if (w_capture) begin
                r_rspRdata <= w_captureData;
                r_rspResp  <= w_captureResp;
            end
        end
    end

    assign cmd_ready     = r_cmdReady;
    assign rsp_valid     = r_rspValid;
    assign rsp_write     = r_write;
    assign rsp_rdata     = r_rspRdata;
    assign rsp_resp      = r_rspResp;
    assign rsp_latency   = r_latency;

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- AXI4-Lite initiator: turns a simple command/response stream into single AXI4-Lite read or write transactions.
- Drives the S_AXI port of axi_regfile_v1_0_S00_AXI from fabric logic, for hardware self-test and register bring-up without the PS.
- One transaction outstanding at a time.
- Reports response code, read data and a per-transaction latency count.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32: AXI address width; cmd_addr width.
- C_M_AXI_DATA_WIDTH, 32: data width. Only 32 is supported; any other value is a generate-time error.
- LAT_WIDTH, 16: width of the saturating latency counter.

Ports:
- axi_aclk  in  1  clock
- axi_areset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  write strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted when valid&&ready
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  32  read data; 0 for writes
- rsp_resp  out  2  BRESP or RRESP
- rsp_latency  out  LAT_WIDTH  cycles from command accept to B/R handshake, saturating
- M_AXI_AWADDR/AWPROT/AWVALID out, AWREADY in: AWPROT is fixed 3'b000
- M_AXI_WDATA/WSTRB/WVALID out, WREADY in
- M_AXI_BRESP/BVALID in, BREADY out
- M_AXI_ARADDR/ARPROT/ARVALID out, ARREADY in: ARPROT is fixed 3'b000
- M_AXI_RDATA/RRESP/RVALID in, RREADY out

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0, including all VALID/READY, rsp_*, cmd_ready and latency.
- Reset mid-transaction aborts the transaction and drops all VALIDs immediately. The interconnect is reset by the same reset.
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, RESP.
- IDLE:
  - cmd_ready=1.
  - On accept, latch addr/wdata/wstrb/write and clear the latency counter.
  - Write: go to WADDR with AWVALID=1 and WVALID=1 in the next cycle.
  - Read: go to RADDR with ARVALID=1.
  - Minimum latency from accept to VALID is 1 cycle.
- WADDR:
  - AW and W complete independently.
  - Each VALID drops the cycle after its own handshake and never re-asserts.
  - When both are done, go to WRESP with BREADY=1.
  - Both handshakes may occur in the same cycle.
  - AWADDR/WDATA/WSTRB stay stable while the corresponding VALID is high.
- WRESP: BREADY=1. On BVALID, capture BRESP, set rsp_rdata=0, go to RESP.
- RADDR: ARVALID held until ARREADY, then go to RDATA with RREADY=1.
- RDATA: on RVALID, capture RDATA/RRESP, go to RESP.
- BREADY/RREADY are 0 outside WRESP/RDATA.
- RESP:
  - rsp_valid=1; payload stable until rsp_ready.
  - On handshake, return to IDLE; cmd_ready rises the next cycle (no back-to-back bypass).
- cmd_ready=0 in every state except IDLE.
- Latency counter:
  - Increments every cycle from WADDR/RADDR entry through the cycle of the B/R handshake.
  - Saturates at all-ones.
  - Frozen in RESP.
- SLVERR/DECERR are passed through unmodified; the block never retries.
- VALID outputs never depend combinationally on READY inputs; all AXI outputs are registered.

Decomposition:
- Package axi_lite_pkg:
  - typedef resp_t (2-bit) with constants RESP_OKAY/EXOKAY/SLVERR/DECERR.
  - enum state_t for the FSM.
  - Shared by the regfile and future AXI-Lite blocks.
- No sub-module required. The saturating counter is inline.
- The bench pairs this block with axi_regfile_v1_0_S00_AXI (C_S_AXI_ADDR_WIDTH=6).

Test Plan:
- Read addr 0x00 via regfile -> rsp_rdata=32'hdeadbeef, rsp_resp=2'b00, rsp_write=0. Read 0x04 -> 32'h76543210.
- Write 0x08 data 32'h00000003 strb 4'hF, then read 0x08 -> read returns 32'h00000003; regfile slv_reg[2][1:0]=2'b11.
- Write 0x0C data 32'hAABBCCDD strb 4'b0101 over prior 0 -> read back 32'h00BB00DD.
- Stub slave with AWREADY 3 cycles before WREADY, BVALID 2 cycles later:
  - each VALID drops exactly after its own handshake;
  - rsp_latency equals the observed cycle count;
  - a stub-injected BRESP=2'b10 returns rsp_resp=2'b10.
- rsp_ready held low 10 cycles -> rsp_* stable, cmd_ready=0, no new AXI activity. Stub stalled for more than 65535 cycles -> rsp_latency=16'hFFFF.
- Assert axi_areset while ARVALID=1 -> ARVALID, rsp_valid and cmd_ready go 0 without waiting for a clock edge. After release, a fresh read of 0x00 completes normally.
